// File: rtl/fifo_pkt_reader_if.sv
// FIFO read port plus switch output port of the packet reader.
// PKT_READER_CNT_EN adds the pkt_cnt/drop_cnt statistics outputs.
interface fifo_pkt_reader_if #(
    parameter int DATA = 8
);
    logic            fifo_empty;
    logic            read_req;
    logic [DATA-1:0] read_data;
    logic            read_data_valid;
    logic [DATA-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_dest;
    logic            len_err;
`ifdef PKT_READER_CNT_EN
    logic [15:0]     pkt_cnt;
    logic [15:0]     drop_cnt;

    modport master (
        input  fifo_empty, read_data, read_data_valid, out_ready,
        output read_req, out_data, out_valid, out_sop, out_eop, out_dest, len_err,
        output pkt_cnt, drop_cnt
    );
    modport slave (
        output fifo_empty, read_data, read_data_valid, out_ready,
        input  read_req, out_data, out_valid, out_sop, out_eop, out_dest, len_err,
        input  pkt_cnt, drop_cnt
    );
`else
    modport master (
        input  fifo_empty, read_data, read_data_valid, out_ready,
        output read_req, out_data, out_valid, out_sop, out_eop, out_dest, len_err
    );
    modport slave (
        output fifo_empty, read_data, read_data_valid, out_ready,
        input  read_req, out_data, out_valid, out_sop, out_eop, out_dest, len_err
    );
`endif
endinterface

// File: rtl/fifo_pkt_reader.sv
// Packet FIFO consumer: parses 1-byte headers {dest,len}, streams payload with sop/eop via a 2-entry skid buffer.
// First byte valid 2 cycles after the header arrives; read_req is credit-gated and ignores out_ready. PKT_READER_CNT_EN adds counters.
module fifo_pkt_reader #(
    parameter int DATA    = 8,
    parameter int MAX_LEN = 48
) (
    input logic               clk,
    input logic               rst,
    fifo_pkt_reader_if.master bus
);
    typedef enum logic [1:0] {HDR, PAY, DROP} state_t;

    typedef struct packed {
        logic            sop;
        logic            eop;
        logic [1:0]      dest;
        logic [DATA-1:0] data;
    } ent_t;

    localparam logic [5:0] MAX_L = 6'(MAX_LEN);

    state_t     state;
    logic [5:0] remaining;
    logic [1:0] dest_q;
    logic       sop_pend;
    logic       len_err_q;
    logic       inflight;
    logic [1:0] buf_count;
    ent_t       ent0;
    ent_t       ent1;

    logic       rx;
    logic       push;
    logic       pop;
    logic [5:0] hdr_len;
    ent_t       new_ent;

    // Only a byte we actually requested counts; stray valids are dropped.
    assign rx      = bus.read_data_valid & inflight;
    assign hdr_len = bus.read_data[5:0];
    assign push    = rx & (state == PAY);
    assign pop     = (buf_count != 2'd0) & bus.out_ready;

    // The in-flight byte holds a credit, so it always finds a free slot.
    assign bus.read_req = !rst & !bus.fifo_empty &
                          ((buf_count + {1'b0, inflight}) < 2'd2);

    always_comb begin
        new_ent      = '0;
        new_ent.sop  = sop_pend;
        new_ent.eop  = (remaining == 6'd1);
        new_ent.dest = dest_q;
        new_ent.data = bus.read_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.read_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            remaining <= '0;
            dest_q    <= '0;
            sop_pend  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            if (rx) begin
                case (state)
                    HDR: begin
                        if (hdr_len == 6'd0) begin
                            len_err_q <= 1'b1;
                        end else if (hdr_len > MAX_L) begin
                            len_err_q <= 1'b1;
                            remaining <= hdr_len;
                            state     <= DROP;
                        end else begin
                            dest_q    <= bus.read_data[7:6];
                            remaining <= hdr_len;
                            sop_pend  <= 1'b1;
                            state     <= PAY;
                        end
                    end
                    PAY: begin
                        remaining <= remaining - 6'd1;
                        sop_pend  <= 1'b0;
                        if (remaining == 6'd1) state <= HDR;
                    end
                    DROP: begin
                        remaining <= remaining - 6'd1;
                        if (remaining == 6'd1) state <= HDR;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

    // ent0 is always the head; ent1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_count <= '0;
            ent0      <= '0;
            ent1      <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_count == 2'd0) ent0 <= new_ent;
                    else                   ent1 <= new_ent;
                    buf_count <= buf_count + 2'd1;
                end
                2'b01: begin
                    ent0      <= ent1;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        ent0 <= new_ent;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= new_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (buf_count != 2'd0);
    assign bus.out_data  = ent0.data;
    assign bus.out_sop   = ent0.sop & bus.out_valid;
    assign bus.out_eop   = ent0.eop & bus.out_valid;
    assign bus.out_dest  = ent0.dest;
    assign bus.len_err   = len_err_q;

`ifdef PKT_READER_CNT_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pop && ent0.eop && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (len_err_q && drop_cnt_q != 16'hFFFF)      drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.pkt_cnt  = pkt_cnt_q;
    assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO model, packet-level scoreboard, directed table and random soak.
module tb_fifo_pkt_reader;
    localparam int MAX_LEN = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_pkt_reader_if #(.DATA(8)) bus ();

    fifo_pkt_reader #(.DATA(8), .MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [1:0] dest;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] base;
        int         ready;
        int         exp_err;
        int         exp_nout;
        logic [1:0] exp_dest;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    int errors = 0, checks = 0, cyc = 0;
    int ready_pct = 100, hold_low = 0;
    int err_seen = 0, err_exp = 0, pkt_exp = 0, fifo_pops = 0, n_acc = 0;
    bit spur = 0, prev_hold = 0, lat_arm = 0;
    exp_t held;
    logic [1:0] last_dest = 2'd0;
    int hdr_cyc = -1, fv_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Legal packets become expected output records; illegal ones only an error pulse.
    task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] base, input bit rnd);
        int len;
        bit legal;
        logic [7:0] b;
        len   = int'(hdr[5:0]);
        legal = (len != 0) && (len <= MAX_LEN);
        fq.push_back(hdr);
        if (!legal) err_exp++;
        else        pkt_exp++;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            fq.push_back(b);
            if (legal) exp_q.push_back('{sop: (i == 0), eop: (i == len - 1), dest: hdr[7:6], data: b});
        end
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic step();
        logic req;
        exp_t got;
        exp_t want;
        @(negedge clk);
        req = bus.read_req;
        if (!rst) begin
            if (bus.fifo_empty) chk("read_req_while_empty", 32'(req), 32'd0);
            if (bus.len_err) err_seen++;
            got = '{bus.out_sop, bus.out_eop, bus.out_dest, bus.out_data};
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_fields", 32'(got), 32'(held));
            end
            if (lat_arm && bus.out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                n_acc++;
                last_dest = bus.out_dest;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_byte: got %0h expected nothing", got);
                end else begin
                    want = exp_q.pop_front();
                    chk("out_byte", 32'(got), 32'(want));
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            held      = got;
        end else begin
            prev_hold = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (req) begin
            fifo_pops++;
            bus.read_data       = (fq.size() > 0) ? fq.pop_front() : 8'h00;
            bus.read_data_valid = 1'b1;
            if (lat_arm && hdr_cyc < 0) hdr_cyc = cyc;
        end else if (spur) begin
            bus.read_data       = 8'h01;
            bus.read_data_valid = 1'b1;
            spur                = 0;
        end else begin
            bus.read_data       = 8'($urandom);
            bus.read_data_valid = 1'b0;
        end
        bus.fifo_empty = (fq.size() == 0);
        if (hold_low > 0) begin
            bus.out_ready = 1'b0;
            hold_low--;
        end else begin
            bus.out_ready = ($urandom_range(99) < ready_pct);
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((fq.size() > 0 || exp_q.size() > 0 || bus.out_valid) && k < 3000) begin
            step();
            k++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (4) step();
        chk({name, "_len_err_count"}, 32'(err_seen), 32'(err_exp));
`ifdef PKT_READER_CNT_EN
        chk({name, "_pkt_cnt"}, 32'(bus.pkt_cnt), 32'(pkt_exp));
        chk({name, "_drop_cnt"}, 32'(bus.drop_cnt), 32'(err_exp));
`endif
    endtask

    // Upstream flushes the FIFO together with the reset.
    task automatic reset_check(input string name);
        rst = 1'b1;
        fq.delete();
        exp_q.delete();
        bus.fifo_empty = 1'b1;
        step();
        chk({name, "_read_req"}, 32'(bus.read_req), 32'd0);
        chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_out_sop"}, 32'(bus.out_sop), 32'd0);
        chk({name, "_out_eop"}, 32'(bus.out_eop), 32'd0);
        chk({name, "_out_dest"}, 32'(bus.out_dest), 32'd0);
        chk({name, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({name, "_len_err"}, 32'(bus.len_err), 32'd0);
`ifdef PKT_READER_CNT_EN
        chk({name, "_pkt_cnt"}, 32'(bus.pkt_cnt), 32'd0);
        chk({name, "_drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
`endif
        rst = 1'b0;
        err_seen = 0;
        err_exp  = 0;
        pkt_exp  = 0;
    endtask

    initial begin
        vec_t vt[9];
        int n0, e0, p0, k, len;
        logic [1:0] d;

        vt[0] = '{8'h83, 8'hA1, 100, 0, 3, 2'd2};
        vt[1] = '{8'h41, 8'h55, 100, 0, 1, 2'd1};
        vt[2] = '{8'hC2, 8'h66, 60, 0, 2, 2'd3};
        vt[3] = '{8'h00, 8'h00, 100, 1, 0, 2'd0};
        vt[4] = '{8'h3F, 8'h20, 50, 1, 0, 2'd0};
        vt[5] = '{8'h01, 8'h99, 100, 0, 1, 2'd0};
        vt[6] = '{8'h70, 8'h40, 70, 0, 48, 2'd1};
        vt[7] = '{8'h71, 8'h10, 100, 1, 0, 2'd0};
        vt[8] = '{8'hFF, 8'hC0, 40, 1, 0, 2'd0};

        bus.fifo_empty      = 1'b1;
        bus.read_data       = 8'h00;
        bus.read_data_valid = 1'b0;
        bus.out_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_check("init");

        // Single packet with first-byte latency measurement.
        lat_arm = 1;
        push_pkt(8'h83, 8'hA1, 0);
        drain("single");
        lat_arm = 0;
        chk("first_byte_latency", 32'(fv_cyc - hdr_cyc), 32'd2);
        chk("single_dest", 32'(last_dest), 32'd2);

        for (int i = 0; i < 9; i++) begin
            ready_pct = vt[i].ready;
            n0 = n_acc;
            e0 = err_seen;
            push_pkt(vt[i].hdr, vt[i].base, 0);
            drain("vec");
            chk("vec_err_pulses", 32'(err_seen - e0), 32'(vt[i].exp_err));
            chk("vec_nout", 32'(n_acc - n0), 32'(vt[i].exp_nout));
            if (vt[i].exp_nout > 0) chk("vec_dest", 32'(last_dest), 32'(vt[i].exp_dest));
        end

        // Back-to-back packets, then the error mix, queued together.
        ready_pct = 100;
        n0 = n_acc;
        push_pkt(8'h41, 8'h55, 0);
        push_pkt(8'hC2, 8'h66, 0);
        drain("b2b");
        chk("b2b_nout", 32'(n_acc - n0), 32'd3);
        n0 = n_acc;
        e0 = err_seen;
        push_pkt(8'h00, 8'h00, 0);
        push_pkt(8'h3F, 8'h00, 1);
        push_pkt(8'h01, 8'h99, 0);
        drain("errmix");
        chk("errmix_pulses", 32'(err_seen - e0), 32'd2);
        chk("errmix_nout", 32'(n_acc - n0), 32'd1);

        // Backpressure: sink stalled from before the first valid for 5 cycles.
        hold_low = 1000;
        step();
        p0 = fifo_pops;
        n0 = n_acc;
        push_pkt(8'h04, 8'h10, 0);
        fq[1] = 8'h10; fq[2] = 8'h20; fq[3] = 8'h30; fq[4] = 8'h40;
        exp_q[0].data = 8'h10; exp_q[1].data = 8'h20; exp_q[2].data = 8'h30; exp_q[3].data = 8'h40;
        k = 0;
        while (!bus.out_valid && k < 50) begin
            step();
            k++;
        end
        chk("bp_valid_seen", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data_held", 32'(bus.out_data), 32'h10);
            chk("bp_occupancy_le2", 32'((fifo_pops - p0 - 1 - (n_acc - n0)) <= 2), 32'd1);
        end
        chk("bp_reads_stalled", 32'(fifo_pops - p0), 32'd3);
        hold_low = 0;
        drain("bp");
        chk("bp_nout", 32'(n_acc - n0), 32'd4);

        // A read_data_valid with nothing in flight must be ignored.
        n0 = n_acc;
        e0 = err_seen;
        spur = 1;
        repeat (6) step();
        chk("spur_nout", 32'(n_acc - n0), 32'd0);
        chk("spur_no_err", 32'(err_seen - e0), 32'd0);
        push_pkt(8'h01, 8'h5A, 0);
        drain("after_spur");
        chk("after_spur_nout", 32'(n_acc - n0), 32'd1);

        // Reset after two of five payload bytes.
        n0 = n_acc;
        push_pkt(8'h05, 8'hB0, 0);
        k = 0;
        while (n_acc - n0 < 2 && k < 50) begin
            step();
            k++;
        end
        chk("mid_two_out", 32'(n_acc - n0), 32'd2);
        reset_check("mid_rst");
        n0 = n_acc;
        push_pkt(8'h01, 8'hAA, 0);
        drain("post_rst");
        chk("post_rst_nout", 32'(n_acc - n0), 32'd1);

        // Random soak.
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) ready_pct = $urandom_range(100, 20);
            if (fq.size() < 6) begin
                k = $urandom_range(99);
                if (k < 8)       len = 0;
                else if (k < 16) len = $urandom_range(63, MAX_LEN + 1);
                else             len = $urandom_range(MAX_LEN, 1);
                d = 2'($urandom);
                push_pkt({d, 6'(len)}, 8'h00, 1);
            end
            step();
        end
        ready_pct = 100;
        drain("soak");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
